// File: rtl/text_layer_pkg.sv
// Shared definitions for the text overlay generator.
// Holds character-cell geometry, the font ROM address width, the blank
// character code and the per-string placement record.
package text_layer_pkg;

    localparam int CHAR_W     = 8;    // pixels per character cell, horizontally
    localparam int CHAR_H     = 16;   // pixels per character cell, vertically
    localparam int FONT_ADR_W = 11;   // {char[7:0], row[3:0]} minus the char MSB overlap
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Placement of one string. len is kept 8 bits wide so the record does not
    // depend on MAX_LEN; the top zero-extends its clamped length into it.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] len;
    } str_cfg_t;

endpackage

// File: rtl/text_region_match.sv
// Box test for one string against the current scan position.
// Ports:
//   curr_x, curr_y  scan position
//   pix_valid       position is visible; low forces hit = 0
//   cfg             active placement of this string
//   hit             position lies inside the string's box
//   slot, row, col  character slot, glyph row and glyph column at the position
module text_region_match
    import text_layer_pkg::*;
(
    input  logic [9:0] curr_x,
    input  logic [9:0] curr_y,
    input  logic       pix_valid,
    input  str_cfg_t   cfg,
    output logic       hit,
    output logic [6:0] slot,
    output logic [3:0] row,
    output logic [2:0] col
);

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x_lo;
    logic [10:0] y_lo;
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    logic [9:0]  dx;

    // Compare in 11 bits so a box running past column 1023 ends there instead
    // of wrapping back to column 0.
    assign px   = {1'b0, curr_x};
    assign py   = {1'b0, curr_y};
    assign x_lo = {1'b0, cfg.x};
    assign y_lo = {1'b0, cfg.y};
    assign x_hi = x_lo + {cfg.len, 3'b000};   // len * CHAR_W
    assign y_hi = y_lo + 11'(CHAR_H);

    assign hit = pix_valid & (cfg.len != 8'd0)
               & (px >= x_lo) & (px < x_hi)
               & (py >= y_lo) & (py < y_hi);

    // Offsets are only meaningful when hit is set; the low bits are enough.
    assign dx   = curr_x - cfg.x;
    assign slot = dx[9:3];
    assign col  = dx[2:0];
    assign row  = curr_y[3:0] - cfg.y[3:0];

endmodule

// File: rtl/text_layer_gen.sv
// Multi-string text overlay generator.
// Maps each scan position to a font ROM address through a 4-stage pipeline
// and returns the addressed font bit as a per-pixel overlay flag.
// Ports:
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   curr_x, curr_y, pix_valid  scan position and visibility
//   frame_start                commits pending string placements
//   cfg_*                      placement handshake (x, y, len per string)
//   wr_*                       character write handshake
//   font_adr / font_data       shared synchronous font ROM (1-cycle latency)
//   txt_valid, txt_hit, txt_on, txt_sel   overlay outputs, 4 cycles after inputs
module text_layer_gen
    import text_layer_pkg::*;
#(
    parameter int NUM_STR = 2,
    parameter int MAX_LEN = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int IDX_W = $clog2(MAX_LEN),
    localparam int SEL_W = (NUM_STR > 1) ? $clog2(NUM_STR) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            curr_x,
    input  logic [9:0]            curr_y,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [9:0]            cfg_x,
    input  logic [9:0]            cfg_y,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_char,
    output logic [FONT_ADR_W-1:0] font_adr,
    input  logic [7:0]            font_data,
    output logic                  txt_valid,
    output logic                  txt_hit,
    output logic                  txt_on,
    output logic [SEL_W-1:0]      txt_sel
);

    localparam logic [SEL_W:0] NUM_STR_L = (SEL_W + 1)'(NUM_STR);
    localparam logic [IDX_W:0] MAX_LEN_L = (IDX_W + 1)'(MAX_LEN);

    // ---------------- configuration and character storage ----------------
    str_cfg_t              active_q [NUM_STR];
    str_cfg_t              active_d [NUM_STR];
    str_cfg_t              shadow_q [NUM_STR];
    str_cfg_t              shadow_d [NUM_STR];
    logic [NUM_STR-1:0]    pending_q;
    logic [NUM_STR-1:0]    pending_d;
    logic                  wr_ready_q;
    logic [7:0]            char_mem_q [NUM_STR][MAX_LEN];

    logic                  cfg_sel_ok;
    logic                  cfg_accept;
    logic [LEN_W-1:0]      len_clamped;
    logic                  wr_en;

    assign cfg_sel_ok  = {1'b0, cfg_sel} < NUM_STR_L;
    assign cfg_ready   = cfg_sel_ok ? ~pending_q[cfg_sel] : 1'b1;
    assign cfg_accept  = cfg_valid & cfg_ready & cfg_sel_ok;
    assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    assign wr_ready = wr_ready_q;
    // Out-of-range targets complete the handshake but write nothing.
    assign wr_en = wr_valid & wr_ready_q
                 & ({1'b0, wr_sel} < NUM_STR_L)
                 & ({1'b0, wr_idx} < MAX_LEN_L);

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        for (int s = 0; s < NUM_STR; s++) begin
            if (frame_start && pending_q[s]) begin
                active_d[s]  = shadow_q[s];
                pending_d[s] = 1'b0;
            end
        end
        // Accept needs pending clear, so it never collides with a commit of
        // the same string; a same-cycle accept waits for the next frame_start.
        if (cfg_accept) begin
            shadow_d[cfg_sel]  = '{x: cfg_x, y: cfg_y, len: 8'(len_clamped)};
            pending_d[cfg_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STR; s++) begin
                active_q[s] <= '0;
                shadow_q[s] <= '0;
                for (int c = 0; c < MAX_LEN; c++) begin
                    char_mem_q[s][c] <= SPACE_CHAR;
                end
            end
            pending_q  <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            wr_ready_q <= 1'b1;
            if (wr_en) begin
                char_mem_q[wr_sel][wr_idx] <= wr_char;
            end
        end
    end

    // ---------------- per-string box test ----------------
    logic [NUM_STR-1:0] hit_vec;
    logic [6:0]         slot_arr [NUM_STR];
    logic [3:0]         row_arr  [NUM_STR];
    logic [2:0]         col_arr  [NUM_STR];

    for (genvar gi = 0; gi < NUM_STR; gi++) begin : g_match
        text_region_match u_match (
            .curr_x    (curr_x),
            .curr_y    (curr_y),
            .pix_valid (pix_valid),
            .cfg       (active_q[gi]),
            .hit       (hit_vec[gi]),
            .slot      (slot_arr[gi]),
            .row       (row_arr[gi]),
            .col       (col_arr[gi])
        );
    end

    // ---------------- pipeline ----------------
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_hit_q,   s1_hit_d;
    logic [SEL_W-1:0]      s1_sel_q,   s1_sel_d;
    logic [6:0]            s1_slot_q,  s1_slot_d;
    logic [3:0]            s1_row_q,   s1_row_d;
    logic [2:0]            s1_col_q,   s1_col_d;
    logic                  s2_valid_q, s2_hit_q, s3_valid_q, s3_hit_q;
    logic [SEL_W-1:0]      s2_sel_q,   s3_sel_q;
    logic [2:0]            s2_col_q,   s3_col_q;
    logic [7:0]            char_rd;
    logic [FONT_ADR_W-1:0] font_adr_q, font_adr_d;
    logic                  txt_valid_q, txt_hit_q, txt_on_q, txt_on_d;
    logic [SEL_W-1:0]      txt_sel_q;

    always_comb begin
        s1_valid_d = pix_valid;
        s1_hit_d   = 1'b0;
        s1_sel_d   = '0;
        s1_slot_d  = '0;
        s1_row_d   = '0;
        s1_col_d   = '0;
        // Walk from the highest index down so the lowest hitting string wins.
        for (int i = NUM_STR - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                s1_hit_d  = 1'b1;
                s1_sel_d  = SEL_W'(i);
                s1_slot_d = slot_arr[i];
                s1_row_d  = row_arr[i];
                s1_col_d  = col_arr[i];
            end
        end
        char_rd = (s1_slot_q < 7'(MAX_LEN)) ? char_mem_q[s1_sel_q][IDX_W'(s1_slot_q)]
                                            : SPACE_CHAR;
        font_adr_d = {char_rd[FONT_ADR_W-5:0], s1_row_q};
        // font_data answers the address issued one cycle earlier.
        txt_on_d = s3_hit_q & font_data[3'd7 - s3_col_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_sel_q    <= '0;
            s1_slot_q   <= '0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_sel_q    <= '0;
            s2_col_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_hit_q    <= 1'b0;
            s3_sel_q    <= '0;
            s3_col_q    <= '0;
            font_adr_q  <= '0;
            txt_valid_q <= 1'b0;
            txt_hit_q   <= 1'b0;
            txt_on_q    <= 1'b0;
            txt_sel_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_sel_q    <= s1_sel_d;
            s1_slot_q   <= s1_slot_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s2_valid_q  <= s1_valid_q;
            s2_hit_q    <= s1_hit_q;
            s2_sel_q    <= s1_sel_q;
            s2_col_q    <= s1_col_q;
            font_adr_q  <= font_adr_d;
            s3_valid_q  <= s2_valid_q;
            s3_hit_q    <= s2_hit_q;
            s3_sel_q    <= s2_sel_q;
            s3_col_q    <= s2_col_q;
            txt_valid_q <= s3_valid_q;
            txt_hit_q   <= s3_hit_q;
            txt_on_q    <= txt_on_d;
            txt_sel_q   <= s3_sel_q;
        end
    end

    assign font_adr  = font_adr_q;
    assign txt_valid = txt_valid_q;
    assign txt_hit   = txt_hit_q;
    assign txt_on    = txt_on_q;
    assign txt_sel   = txt_sel_q;

endmodule

// File: tb/tb_text_layer_gen.sv
// Directed bench for text_layer_gen: reset state, pipeline latency,
// placement/commit handshake, priority, clamping, right-edge clipping and
// asynchronous reset.
module tb_text_layer_gen;

    localparam int SEL_W = 1;
    localparam int LEN_W = 5;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [9:0]       curr_x, curr_y;
    logic             pix_valid, frame_start;
    logic             cfg_valid, cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [9:0]       cfg_x, cfg_y;
    logic [LEN_W-1:0] cfg_len;
    logic             wr_valid, wr_ready;
    logic [SEL_W-1:0] wr_sel;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_char;
    logic [10:0]      font_adr;
    logic [7:0]       font_data = 8'h00;
    logic             txt_valid, txt_hit, txt_on;
    logic [SEL_W-1:0] txt_sel;

    logic [7:0]       rom_row;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    // Synchronous font ROM stand-in: every address returns rom_row.
    always @(posedge clk) font_data <= rom_row;

    text_layer_gen #(.NUM_STR(2), .MAX_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .curr_x(curr_x), .curr_y(curr_y),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_len(cfg_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
        .wr_idx(wr_idx), .wr_char(wr_char),
        .font_adr(font_adr), .font_data(font_data),
        .txt_valid(txt_valid), .txt_hit(txt_hit), .txt_on(txt_on), .txt_sel(txt_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic s, input int x, input int y, input int len);
        cfg_sel = s; cfg_x = 10'(x); cfg_y = 10'(y); cfg_len = 5'(len); cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wr(input logic s, input int idx, input logic [7:0] ch);
        wr_sel = s; wr_idx = 4'(idx); wr_char = ch; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // One pixel through the pipe: font_adr after 2 edges, outputs after 4.
    task automatic probe(input string tag, input int x, input int y, input bit do_adr,
                         input logic [10:0] e_adr, input logic e_hit, input logic e_on,
                         input logic e_sel);
        curr_x = 10'(x); curr_y = 10'(y); pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        if (do_adr) chk({tag, " font_adr"}, 32'(font_adr), 32'(e_adr));
        tick();
        tick();
        chk({tag, " txt_valid"}, 32'(txt_valid), 32'd1);
        chk({tag, " txt_hit"}, 32'(txt_hit), 32'(e_hit));
        chk({tag, " txt_on"}, 32'(txt_on), 32'(e_on));
        chk({tag, " txt_sel"}, 32'(txt_sel), 32'(e_sel));
        $display("probe %s (%0d,%0d): adr=%h hit=%b on=%b sel=%0d",
                 tag, x, y, font_adr, txt_hit, txt_on, txt_sel);
    endtask

    initial begin
        logic [39:0] pv_hist;
        string       hello;
        hello = "HELLO";
        rst_n = 1'b0; curr_x = '0; curr_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
        cfg_valid = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0; cfg_len = '0;
        wr_valid = 1'b0; wr_sel = '0; wr_idx = '0; wr_char = '0; rom_row = 8'h80;
        pv_hist = '0;

        // Reset state
        tick(); tick();
        chk("rst wr_ready", 32'(wr_ready), 32'd0);
        chk("rst cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst txt_valid", 32'(txt_valid), 32'd0);
        chk("rst txt_hit", 32'(txt_hit), 32'd0);
        chk("rst font_adr", 32'(font_adr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post-rst wr_ready", 32'(wr_ready), 32'd1);

        // Unconfigured sweep: no hits, txt_valid is pix_valid delayed by 4
        for (int i = 0; i < 40; i++) begin
            pv_hist[i] = ((i % 7) < 5);
            pix_valid = pv_hist[i];
            curr_x = 10'(i * 25);
            curr_y = 10'(i);
            tick();
            if (i >= 3) begin
                chk("sweep txt_valid", 32'(txt_valid), 32'(pv_hist[i-3]));
                chk("sweep txt_hit", 32'(txt_hit), 32'd0);
            end
        end
        pix_valid = 1'b0;
        $display("sweep done");

        // String 0 "HELLO" at (100,50)
        cfg(1'b0, 100, 50, 5);
        frame();
        for (int i = 0; i < 5; i++) wr(1'b0, i, hello[i]);
        probe("s0 100,50", 100, 50, 1, 11'h480, 1'b1, 1'b1, 1'b0);
        probe("s0 101,50", 101, 50, 1, 11'h480, 1'b1, 1'b0, 1'b0);
        probe("s0 139,65", 139, 65, 1, 11'h4FF, 1'b1, 1'b0, 1'b0);
        probe("s0 140,50", 140, 50, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        probe("s0 99,50", 99, 50, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        probe("s0 100,66", 100, 66, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        rom_row = 8'h01;
        probe("s0 139,65 rom01", 139, 65, 1, 11'h4FF, 1'b1, 1'b1, 1'b0);
        rom_row = 8'h80;

        // Overlap: lowest index wins; disabling string 0 hands over to string 1
        cfg(1'b1, 100, 50, 5);
        frame();
        probe("overlap", 100, 50, 1, 11'h480, 1'b1, 1'b1, 1'b0);
        cfg(1'b0, 100, 50, 0);
        frame();
        probe("s0 off", 100, 50, 1, 11'h200, 1'b1, 1'b1, 1'b1);

        // Back-to-back cfg on string 0: second cycle blocked, no change before commit
        cfg_sel = 1'b0; cfg_x = 10'd200; cfg_y = 10'd50; cfg_len = 5'd2; cfg_valid = 1'b1;
        chk("cfg_ready first", 32'(cfg_ready), 32'd1);
        tick();
        chk("cfg_ready busy", 32'(cfg_ready), 32'd0);
        cfg_x = 10'd300;
        tick();
        cfg_valid = 1'b0;
        probe("pending 200", 200, 50, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        frame();
        chk("cfg_ready after commit", 32'(cfg_ready), 32'd1);
        probe("commit 200", 200, 50, 1, 11'h480, 1'b1, 1'b1, 1'b0);
        probe("blocked 300", 300, 50, 0, 11'h000, 1'b0, 1'b0, 1'b0);

        // cfg accepted together with frame_start stays pending
        cfg_sel = 1'b1; cfg_x = 10'd400; cfg_y = 10'd50; cfg_len = 5'd1;
        cfg_valid = 1'b1; frame_start = 1'b1;
        tick();
        cfg_valid = 1'b0; frame_start = 1'b0;
        chk("same-cycle pending", 32'(cfg_ready), 32'd0);
        probe("s1 old 100", 100, 50, 0, 11'h000, 1'b1, 1'b1, 1'b1);
        probe("s1 new 400 early", 400, 50, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        frame();
        probe("s1 new 400", 400, 50, 1, 11'h200, 1'b1, 1'b1, 1'b1);

        // Length clamp: 20 -> 16 characters = 128 pixels
        cfg(1'b0, 0, 100, 20);
        frame();
        probe("clamp 127", 127, 100, 1, 11'h200, 1'b1, 1'b0, 1'b0);
        probe("clamp 128", 128, 100, 0, 11'h000, 1'b0, 1'b0, 1'b0);

        // Right edge: no wrap past column 1023
        cfg(1'b0, 1000, 100, 4);
        frame();
        probe("edge 1000", 1000, 100, 1, 11'h480, 1'b1, 1'b1, 1'b0);
        probe("edge 1023", 1023, 100, 1, 11'h4C0, 1'b1, 1'b0, 1'b0);
        probe("wrap 0", 0, 100, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        probe("wrap 7", 7, 100, 0, 11'h000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a string
        curr_x = 10'd1000; curr_y = 10'd100; pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-rst txt_hit", 32'(txt_hit), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async rst txt_hit", 32'(txt_hit), 32'd0);
        chk("async rst txt_valid", 32'(txt_valid), 32'd0);
        chk("async rst txt_on", 32'(txt_on), 32'd0);
        chk("async rst font_adr", 32'(font_adr), 32'd0);
        chk("async rst wr_ready", 32'(wr_ready), 32'd0);
        pix_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        probe("after rst disabled", 1000, 100, 0, 11'h000, 1'b0, 1'b0, 1'b0);
        cfg(1'b0, 1000, 100, 4);
        frame();
        probe("after rst ram", 1000, 100, 1, 11'h200, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
